// File: rtl/tm_head_controller.sv
// tm_head_controller: drives an 8-cell 2-bit tape as a Turing-machine head,
// one READ/EVAL/WRITE step per transition until halt, tape-edge fault or timeout.
module tm_head_controller #(
  parameter int STATE_W = 4,
  parameter logic [STATE_W-1:0] HALT_STATE = 4'hF,
  parameter logic [2:0] START_HEAD = 3'b000,
  parameter logic [7:0] MAX_STEPS = 8'd255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         tape_out,
  input  logic [1:0]         rule_write,
  input  logic [1:0]         rule_move,
  input  logic [STATE_W-1:0] rule_next,
  output logic               tape_mode,
  output logic [2:0]         tape_head,
  output logic [1:0]         tape_in,
  output logic [STATE_W-1:0] rule_state,
  output logic [1:0]         rule_sym,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [7:0]         steps
);
  typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, DONE} st_t;
  st_t st, nxt;
  logic [STATE_W-1:0] state_q, nx_q;
  logic [2:0] head_q, head_nx;
  logic [7:0] steps_q;
  logic [1:0] wr_q, mv_q;
  logic fault_q, edge_f, halt_f, last_f;
  always_comb begin
    nxt = st;
    edge_f = (mv_q == 2'b01 && head_q == 3'd7) || (mv_q == 2'b10 && head_q == 3'd0);
    halt_f = nx_q == HALT_STATE;
    last_f = steps_q + 8'd1 == MAX_STEPS;
    head_nx = edge_f ? head_q : mv_q == 2'b01 ? head_q + 3'd1 : mv_q == 2'b10 ? head_q - 3'd1 : head_q;
    case (st)
      IDLE, DONE: nxt = start ? READ : st;
      READ:       nxt = EVAL;
      EVAL:       nxt = WRITE;
      WRITE:      nxt = (halt_f || edge_f || last_f) ? DONE : READ;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      state_q <= '0;
      nx_q <= '0;
      head_q <= START_HEAD;
      steps_q <= '0;
      wr_q <= '0;
      mv_q <= '0;
      fault_q <= 1'b0;
    end else begin
      st <= nxt;
      if ((st == IDLE || st == DONE) && start) begin
        state_q <= '0;
        head_q <= START_HEAD;
        steps_q <= '0;
        fault_q <= 1'b0;
      end
      if (st == EVAL) begin
        wr_q <= rule_write;
        mv_q <= rule_move;
        nx_q <= rule_next;
      end
      if (st == WRITE) begin
        state_q <= nx_q;
        steps_q <= steps_q + 8'd1;
        head_q <= head_nx;
        fault_q <= !halt_f && (edge_f || last_f);
      end
    end
  end
  assign tape_mode = st == WRITE;
  assign tape_head = head_q;
  assign tape_in = st == WRITE ? wr_q : 2'b00;
  assign rule_state = state_q;
  assign rule_sym = tape_out;
  assign busy = st == READ || st == EVAL || st == WRITE;
  assign done = st == DONE;
  assign fault = fault_q;
  assign steps = steps_q;
endmodule

// File: tb/tb_tm_head_controller.sv
// tb_tm_head_controller: directed tests of the head controller against a tape model and rule tables.
module tb_tm_head_controller;
  logic clk = 0, reset = 1, start = 0, start2 = 0;
  always #5 clk = ~clk;
  logic [1:0] tape_out, rule_write, rule_move, tape_in, rule_sym;
  logic [3:0] rule_next, rule_state;
  logic tape_mode, busy, done, fault;
  logic [2:0] tape_head;
  logic [7:0] steps;
  logic [1:0] tape_out2, tape_in2, rule_sym2;
  logic [3:0] rule_state2;
  logic tape_mode2, busy2, done2, fault2;
  logic [2:0] tape_head2;
  logic [7:0] steps2;
  logic [1:0] mem [8];
  logic [1:0] init_mem [8];
  logic [1:0] mem2 [8];
  logic load = 0;
  int sel = 0;
  int total = 0, bad = 0;

  tm_head_controller u_dut (
    .clk(clk), .reset(reset), .start(start), .tape_out(tape_out),
    .rule_write(rule_write), .rule_move(rule_move), .rule_next(rule_next),
    .tape_mode(tape_mode), .tape_head(tape_head), .tape_in(tape_in),
    .rule_state(rule_state), .rule_sym(rule_sym), .busy(busy), .done(done),
    .fault(fault), .steps(steps));

  tm_head_controller #(.MAX_STEPS(8'd5)) u_to (
    .clk(clk), .reset(reset), .start(start2), .tape_out(tape_out2),
    .rule_write(2'b00), .rule_move(2'b00), .rule_next(4'h0),
    .tape_mode(tape_mode2), .tape_head(tape_head2), .tape_in(tape_in2),
    .rule_state(rule_state2), .rule_sym(rule_sym2), .busy(busy2), .done(done2),
    .fault(fault2), .steps(steps2));

  always @(posedge clk) begin
    if (load) mem <= init_mem;
    else if (tape_mode) mem[tape_head] <= tape_in;
    else tape_out <= mem[tape_head];
  end

  always @(posedge clk) begin
    if (tape_mode2) mem2[tape_head2] <= tape_in2;
    else tape_out2 <= mem2[tape_head2];
  end

  // sel picks the transition table: 1 run-right, 2 halt, 3 left, 5 unary increment
  always_comb begin
    rule_write = 2'b00;
    rule_move = 2'b00;
    rule_next = 4'h0;
    case (sel)
      1: begin rule_write = 2'b01; rule_move = 2'b01; end
      2: begin rule_write = 2'b01; rule_next = 4'hF; end
      3: rule_move = 2'b10;
      5: begin
        rule_write = 2'b01;
        rule_move = rule_sym == 2'b01 ? 2'b01 : 2'b00;
        rule_next = rule_sym == 2'b01 ? 4'h0 : 4'hF;
      end
      default: ;
    endcase
  end

  task automatic preload(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    for (int i = 0; i < 8; i++) init_mem[i] = 2'b10;
    init_mem[0] = a;
    init_mem[1] = b;
    init_mem[2] = c;
    @(negedge clk) load = 1;
    @(negedge clk) load = 0;
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(output int cyc, output int wr);
    cyc = 0;
    wr = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (busy) cyc++;
      if (tape_mode) wr++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({tape_mode, tape_head, tape_in, rule_state, steps, busy, done, fault} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs got mode=%b head=%0d in=%b st=%0d steps=%0d busy=%b done=%b fault=%b want all 0",
               tape_mode, tape_head, tape_in, rule_state, steps, busy, done, fault);
    end
    reset = 0;
  endtask

  task automatic test_run_right;
    int cyc, wr;
    logic ok;
    sel = 1;
    preload(2'b10, 2'b10, 2'b10);
    pulse_start();
    wait_done(cyc, wr);
    ok = 1;
    for (int i = 0; i < 8; i++) if (mem[i] !== 2'b01) ok = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL run_right_cells got %b%b%b%b%b%b%b%b want all 01", mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]); end
    total++;
    if ({done, fault, steps, tape_head} !== {1'b1, 1'b1, 8'd8, 3'd7}) begin
      bad++; $display("FAIL run_right_end got done=%b fault=%b steps=%0d head=%0d want 1 1 8 7", done, fault, steps, tape_head);
    end
    total++;
    if (cyc !== 24) begin bad++; $display("FAIL run_right_cycles got %0d want 24", cyc); end
  endtask

  task automatic test_halt;
    int cyc, wr;
    sel = 2;
    preload(2'b10, 2'b10, 2'b10);
    pulse_start();
    wait_done(cyc, wr);
    total++;
    if ({done, fault, steps} !== {1'b1, 1'b0, 8'd1}) begin
      bad++; $display("FAIL halt_end got done=%b fault=%b steps=%0d want 1 0 1", done, fault, steps);
    end
    total++;
    if (cyc !== 3 || wr !== 1) begin bad++; $display("FAIL halt_timing got busy=%0d writes=%0d want 3 1", cyc, wr); end
    total++;
    if (mem[0] !== 2'b01) begin bad++; $display("FAIL halt_cell0 got %b want 01", mem[0]); end
    total++;
    if (rule_state !== 4'hF || busy !== 1'b0) begin bad++; $display("FAIL halt_state got state=%h busy=%b want F 0", rule_state, busy); end
  endtask

  task automatic test_left_edge;
    int cyc, wr;
    sel = 3;
    preload(2'b10, 2'b10, 2'b10);
    pulse_start();
    wait_done(cyc, wr);
    total++;
    if ({done, fault, steps, tape_head} !== {1'b1, 1'b1, 8'd1, 3'd0}) begin
      bad++; $display("FAIL left_end got done=%b fault=%b steps=%0d head=%0d want 1 1 1 0", done, fault, steps, tape_head);
    end
    total++;
    if (mem[0] !== 2'b00) begin bad++; $display("FAIL left_cell0 got %b want 00", mem[0]); end
  endtask

  task automatic test_timeout;
    int cyc;
    cyc = 0;
    @(negedge clk) start2 = 1;
    @(negedge clk) start2 = 0;
    for (int i = 0; i < 300 && !done2; i++) begin
      if (busy2) cyc++;
      @(negedge clk);
    end
    total++;
    if ({done2, fault2, steps2} !== {1'b1, 1'b1, 8'd5}) begin
      bad++; $display("FAIL timeout_end got done=%b fault=%b steps=%0d want 1 1 5", done2, fault2, steps2);
    end
    total++;
    if (cyc !== 15) begin bad++; $display("FAIL timeout_cycles got %0d want 15", cyc); end
  endtask

  task automatic test_unary;
    int cyc, wr;
    sel = 5;
    preload(2'b01, 2'b01, 2'b10);
    pulse_start();
    wait_done(cyc, wr);
    total++;
    if ({mem[0], mem[1], mem[2]} !== 6'b010101) begin bad++; $display("FAIL unary_cells got %b %b %b want 01 01 01", mem[0], mem[1], mem[2]); end
    total++;
    if ({done, fault, steps, tape_head} !== {1'b1, 1'b0, 8'd3, 3'd2}) begin
      bad++; $display("FAIL unary_end got done=%b fault=%b steps=%0d head=%0d want 1 0 3 2", done, fault, steps, tape_head);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, wr;
    sel = 1;
    preload(2'b10, 2'b10, 2'b10);
    pulse_start();
    repeat (4) @(negedge clk);
    total++;
    if ({busy, tape_mode, tape_head, rule_sym, steps} !== {1'b1, 1'b0, 3'd1, 2'b10, 8'd1}) begin
      bad++; $display("FAIL eval2_view got busy=%b mode=%b head=%0d sym=%b steps=%0d want 1 0 1 10 1", busy, tape_mode, tape_head, rule_sym, steps);
    end
    reset = 1;
    #1;
    total++;
    if ({tape_mode, tape_head, tape_in, rule_state, steps, busy, done, fault} !== 22'd0) begin
      bad++; $display("FAIL reset_mid got mode=%b head=%0d in=%b st=%0d steps=%0d busy=%b done=%b fault=%b want all 0",
                      tape_mode, tape_head, tape_in, rule_state, steps, busy, done, fault);
    end
    @(negedge clk) reset = 0;
    sel = 2;
    pulse_start();
    wait_done(cyc, wr);
    total++;
    if ({done, fault, steps, cyc} !== {1'b1, 1'b0, 8'd1, 32'd3}) begin
      bad++; $display("FAIL reset_rerun got done=%b fault=%b steps=%0d busy=%0d want 1 0 1 3", done, fault, steps, cyc);
    end
  endtask

  task automatic test_start_mid;
    int cyc, wr;
    sel = 1;
    preload(2'b10, 2'b10, 2'b10);
    pulse_start();
    repeat (5) @(negedge clk);
    start = 1;
    @(negedge clk) start = 0;
    total++;
    if (steps !== 8'd2 || busy !== 1'b1 || tape_head !== 3'd2) begin
      bad++; $display("FAIL start_mid got steps=%0d busy=%b head=%0d want 2 1 2", steps, busy, tape_head);
    end
    wait_done(cyc, wr);
    total++;
    if ({done, fault, steps} !== {1'b1, 1'b1, 8'd8}) begin
      bad++; $display("FAIL start_mid_end got done=%b fault=%b steps=%0d want 1 1 8", done, fault, steps);
    end
  endtask

  initial begin
    test_reset();
    test_run_right();
    test_halt();
    test_left_edge();
    test_timeout();
    test_unary();
    test_reset_mid();
    test_start_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tm_head_controller.md
# tm_head_controller

Sequencing controller that drives the 8-cell, 2-bit-symbol tape store as a Turing-machine head. Each step, it reads the symbol under the head and looks it up in an external transition table. It then writes the new symbol, moves the head and updates the machine state. It is the initiator for the tape: it owns `mode`/`head`/`in` and consumes the tape's registered `out`. It runs from `start` until it reaches the halt state, hits a tape-edge fault or hits a step timeout.

## Interface
- `STATE_W`, 4, width of machine state.
- `HALT_STATE`, 4'hF, state value that stops execution.
- `START_HEAD`, 3'b000, head position loaded on `start`.
- `MAX_STEPS`, 8'd255, step limit before timeout fault.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run from state 0.
- `tape_out`  in  2  tape read data (00=0, 01=1, 1x=blank), registered by tape.
- `rule_write`  in  2  symbol to write for (`rule_state`, `rule_sym`).
- `rule_move`  in  2  00/11 stay, 01 right (+1), 10 left (−1).
- `rule_next`  in  STATE_W  next state.
- `tape_mode`  out  1  0 read, 1 write.
- `tape_head`  out  3  cell address.
- `tape_in`  out  2  write data.
- `rule_state`  out  STATE_W  current state presented to the table.
- `rule_sym`  out  2  symbol read, presented to the table.
- `busy`  out  1  run in progress.
- `done`  out  1  sticky; run ended.
- `fault`  out  1  sticky; run ended abnormally.
- `steps`  out  8  completed steps in current/last run.

## Operation
- FSM states: IDLE, READ, EVAL, WRITE, DONE.
- IDLE:
  - `start` → READ.
  - Loads state=0, head=START_HEAD and steps=0.
  - Clears `done`/`fault`.
- READ:
  - Drives `tape_mode`=0 and `tape_head`=head.
  - The tape captures the cell into `tape_out` at the closing edge.
  - → EVAL.
- EVAL:
  - `tape_mode`=0 and `tape_head` are held.
  - `rule_sym`=`tape_out` (combinational) and `rule_state`=current state.
  - At the closing edge, registers `rule_write`, `rule_move` and `rule_next`.
  - → WRITE.
- WRITE:
  - Drives `tape_mode`=1, `tape_head`=head and `tape_in`=latched write symbol; the tape stores it at the closing edge.
  - At the same edge: state←next, steps←steps+1, head updated per move.
  - Then:
    - If next==HALT_STATE → DONE, fault=0.
    - Else if the move leaves 0..7 (left at 0, right at 7) → DONE, fault=1, head unchanged; the write still commits.
    - Else if steps+1 == MAX_STEPS → DONE, fault=1.
    - Else → READ.
- DONE:
  - `done`=1, `tape_mode`=0; `fault` and `steps` are held.
  - `start` → same init as IDLE, then READ.
- Priority when several end conditions hit on one step: halt > edge fault > timeout.
- `start` is ignored in READ/EVAL/WRITE.
- Blank symbols (1x) are forwarded unmodified to `rule_sym`; the table decides.
- Head arithmetic is 3-bit and never wraps; an out-of-range move is a fault, not a wrap.
- `steps` saturates by construction (timeout stops at MAX_STEPS).

## Timing
- Reset (async, any state):
  - FSM→IDLE.
  - `tape_mode`=0, `tape_head`=START_HEAD, `tape_in`=00.
  - state=0, `steps`=0, `busy`=0, `done`=0, `fault`=0.
- Reset mid-WRITE: the tape write in that cycle is not guaranteed; the controller must not issue further writes.
- `busy`=1 in READ/EVAL/WRITE, 0 in IDLE/DONE.
- `start` at edge k: READ occupies cycle k+1.
- Each step is 3 cycles: READ, EVAL, WRITE. `tape_mode`=1 only during WRITE, exactly one cycle per step.
- Read latency: the table sees the symbol 1 cycle after READ (the tape's registered output).
- A run of N steps ending in halt asserts `done` N·3 cycles after the READ of step 1 begins.
- The rule table must settle within the EVAL cycle.

## Test plan
- Reset, then `start`; the table always writes 01, moves right, next=0 while head<7.
  - At head 7 it moves right.
  - Required: cells 0..7 all read 01; `fault`=1, `done`=1, `steps`=8, head=7.
- Halt rule: state 0 writes 01, stays, next=F.
  - Required: `done`=1, `fault`=0, `steps`=1 after exactly 3 busy cycles; cell 0=01.
- Left move at START_HEAD=0: state 0 writes 00, moves left.
  - Required: `fault`=1, `steps`=1, head=0; the write to cell 0 is observed.
- Timeout: state 0 writes 00, stays, next=0 forever, with MAX_STEPS=5.
  - Required: `done`=1, `fault`=1, `steps`=5 after 15 busy cycles.
- Unary increment: tape preloaded 01,01,10,….
  - Rule: on 01 move right; on blank write 01 and go to F.
  - Required: cell 2=01, `steps`=3, `fault`=0.
- Assert `reset` during EVAL of step 2.
  - Required: all outputs return to reset values immediately; a subsequent `start` runs a fresh run with `steps` counting from 0.
- Assert `start` mid-run.
  - Required: ignored, and `steps` continues unchanged.
